// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative signed/unsigned multiply and divide unit.
// Each operation is either a shift-add multiply or a restoring divide
// that produces one result bit per cycle. A final fix-up cycle applies
// the signs. A divide by zero skips the datapath and completes at once.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     in_A,
  input  logic [WIDTH-1:0]     in_B,
  output logic                 ready,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // mode[1] selects divide, mode[0] selects signed arithmetic
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   out_q, out_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes for acceptance and the shared add/subtract datapath
  always_comb begin
    a_neg    = mode[0] & in_A[WIDTH-1];
    b_neg    = mode[0] & in_B[WIDTH-1];
    a_mag    = a_neg ? (-in_A) : in_A;
    b_mag    = b_neg ? (-in_B) : in_B;
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    prod_fix = (mode_q[0] & (sign_a_q ^ sign_b_q)) ? (-acc_q) : acc_q;
    quo_fix  = (mode_q[0] & (sign_a_q ^ sign_b_q)) ? (-acc_q[WIDTH-1:0])
                                                   : acc_q[WIDTH-1:0];
    rem_fix  = (mode_q[0] & sign_a_q) ? (-acc_q[2*WIDTH-1:WIDTH])
                                      : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the control FSM, iteration counter and result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    out_d    = out_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          mode_d   = mode;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          opb_d    = b_mag;
          cnt_d    = '0;
          if (mode[1] && (in_B == '0)) begin
            out_d   = {in_A, {WIDTH{1'b1}}};
            state_d = S_OUT;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mode_q[1]) begin
          if (!sub_diff[WIDTH]) begin
            acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end
        end else begin
          if (acc_q[0]) begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        out_d   = mode_q[1] ? {rem_fix, quo_fix} : prod_fix;
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign out   = out_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: directed and randomized checks of mul_div_seq at
// WIDTH=32 and WIDTH=8, against an arithmetic reference model.
module tb_mul_div_seq;

  logic        clk;
  logic        rst_n;

  logic        valid32;
  logic [1:0]  mode32;
  logic [31:0] a32, b32;
  logic        ready32, busy32;
  logic [63:0] out32;

  logic        valid8;
  logic [1:0]  mode8;
  logic [7:0]  a8, b8;
  logic        ready8, busy8;
  logic [15:0] out8;

  int checks_total;
  int checks_passed;
  int checks_failed;

  mul_div_seq #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid32),
    .mode  (mode32),
    .in_A  (a32),
    .in_B  (b32),
    .ready (ready32),
    .busy  (busy32),
    .out   (out32)
  );

  mul_div_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid8),
    .mode  (mode8),
    .in_A  (a8),
    .in_B  (b8),
    .ready (ready8),
    .busy  (busy8),
    .out   (out8)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic on w-bit operands
  function automatic logic [63:0] refModel(input int w, input logic [1:0] m,
                                           input logic [63:0] a_in,
                                           input logic [63:0] b_in);
    logic [63:0] mask_w, a, b, q, r, res;
    longint      sa, sb;
    mask_w = (64'd1 << w) - 64'd1;
    a = a_in & mask_w;
    b = b_in & mask_w;
    sa = longint'(a);
    sb = longint'(b);
    if (m[0] && a[w-1]) sa = sa - (longint'(1) << w);
    if (m[0] && b[w-1]) sb = sb - (longint'(1) << w);
    if (!m[1]) begin
      res = 64'(sa * sb);
      if (w < 32) res = res & ((64'd1 << (2 * w)) - 64'd1);
    end else if (b == 64'd0) begin
      res = (a << w) | mask_w;
    end else begin
      q = 64'(sa / sb) & mask_w;
      r = 64'(sa % sb) & mask_w;
      res = (r << w) | q;
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic driveIn(input int w, input logic v, input logic [1:0] m,
                         input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      valid32 = v; mode32 = m; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      valid8 = v; mode8 = m; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic sampleOut(input int w, output logic rdy, output logic bsy,
                           output logic [63:0] o);
    if (w == 32) begin
      rdy = ready32; bsy = busy32; o = out32;
    end else begin
      rdy = ready8; bsy = busy8; o = {48'd0, out8};
    end
  endtask

  // One operation: issue in cycle 0, then watch ready/busy/out cycle by cycle
  task automatic applyStimulus(input int w, input logic [1:0] m,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] expv, input bit garbage,
                               input string tag);
    int          lat, first_rdy, rdy_cnt;
    bit          busy_ok;
    logic        rdy, bsy;
    logic [63:0] o, got, mask_w;
    mask_w = (64'd1 << w) - 64'd1;
    lat = (m[1] && ((b & mask_w) == 64'd0)) ? 1 : w + 2;
    @(posedge clk); #1;
    driveIn(w, 1'b1, m, a, b);
    @(posedge clk); #1;
    driveIn(w, 1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    first_rdy = 0;
    rdy_cnt   = 0;
    busy_ok   = 1'b1;
    got       = '0;
    for (int cyc = 1; cyc <= w + 4; cyc++) begin
      if (garbage && cyc < lat)
        driveIn(w, 1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      else
        driveIn(w, 1'b0, 2'b00, 64'd0, 64'd0);
      sampleOut(w, rdy, bsy, o);
      if (rdy === 1'b1) begin
        rdy_cnt++;
        if (first_rdy == 0) begin
          first_rdy = cyc;
          got = o;
        end
      end
      if (bsy !== (cyc <= lat)) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput({tag, " ready_cycle"}, 64'(first_rdy), 64'(lat));
    checkOutput({tag, " ready_pulses"}, 64'(rdy_cnt), 64'd1);
    checkOutput({tag, " busy_profile"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, " out"}, got, expv);
    sampleOut(w, rdy, bsy, o);
    checkOutput({tag, " out_hold"}, o, expv);
  endtask

  initial begin
    logic [1:0]  m;
    logic [63:0] a, b;
    int          rdy_cycles[$];
    checks_total  = 0;
    checks_passed = 0;
    checks_failed = 0;
    rst_n = 1'b0;
    driveIn(32, 1'b0, 2'b00, 64'd0, 64'd0);
    driveIn(8, 1'b0, 2'b00, 64'd0, 64'd0);

    #2;
    checkOutput("reset ready32", 64'(ready32), 64'd0);
    checkOutput("reset busy32", 64'(busy32), 64'd0);
    checkOutput("reset out32", out32, 64'd0);
    checkOutput("reset out8", {48'd0, out8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed WIDTH=32 operations");
    applyStimulus(32, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, "multu_max");
    applyStimulus(32, 2'b01, 64'hFFFFFFFD, 64'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, "mul_neg3x7");
    applyStimulus(32, 2'b01, 64'h80000000, 64'h80000000, 64'h40000000_00000000, 1'b0, "mul_min_min");
    applyStimulus(32, 2'b10, 64'd100, 64'd7, 64'h00000002_0000000E, 1'b0, "divu_100_7");
    applyStimulus(32, 2'b11, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "div_neg7_2");
    applyStimulus(32, 2'b11, 64'd7, 64'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, "div_7_neg2");
    applyStimulus(32, 2'b11, 64'h80000000, 64'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "div_overflow");
    applyStimulus(32, 2'b10, 64'h1234, 64'd0, 64'h00001234_FFFFFFFF, 1'b0, "divu_by_zero");
    applyStimulus(32, 2'b11, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b0, "div_by_zero");
    applyStimulus(32, 2'b01, 64'd12345, 64'hFFFFFF00, 64'hFFFFFFFF_FFCF_C700, 1'b1, "mul_valid_garbage");

    $display("[TB] reset in the middle of an operation");
    @(posedge clk); #1;
    driveIn(32, 1'b1, 2'b00, 64'hDEADBEEF, 64'h1234567);
    @(posedge clk); #1;
    driveIn(32, 1'b0, 2'b00, 64'd0, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midreset busy32", 64'(busy32), 64'd0);
    checkOutput("midreset ready32", 64'(ready32), 64'd0);
    checkOutput("midreset out32", out32, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(32, 2'b00, 64'd6, 64'd7, 64'h00000000_0000002A, 1'b0, "multu_after_reset");

    $display("[TB] directed WIDTH=8 operations");
    applyStimulus(8, 2'b00, 64'hFF, 64'hFF, 64'hFE01, 1'b0, "w8_multu_max");
    applyStimulus(8, 2'b11, 64'h80, 64'hFF, 64'h0080, 1'b0, "w8_div_overflow");

    $display("[TB] back-to-back issue with valid held high, WIDTH=8");
    @(posedge clk); #1;
    driveIn(8, 1'b1, 2'b00, 64'd12, 64'd13);
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(posedge clk); #1;
      if (cyc >= 12) driveIn(8, 1'b0, 2'b00, 64'd0, 64'd0);
      if (ready8 === 1'b1) begin
        rdy_cycles.push_back(cyc);
        checkOutput("b2b out", {48'd0, out8}, 64'h009C);
      end
    end
    checkOutput("b2b ready_count", 64'(rdy_cycles.size()), 64'd2);
    if (rdy_cycles.size() == 2) begin
      checkOutput("b2b first_ready", 64'(rdy_cycles[0]), 64'd10);
      checkOutput("b2b second_ready", 64'(rdy_cycles[1]), 64'd21);
    end

    $display("[TB] randomized operations against the reference model");
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 2; k++) begin
        int w;
        w = (k == 0) ? 32 : 8;
        m = 2'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0: b = 64'd0;
          1: b = '1;
          2: b = 64'($urandom_range(1, 9));
          3: a = 64'd1 << (w - 1);
          default: ;
        endcase
        applyStimulus(w, m, a, b, refModel(w, m, a, b), 1'($urandom), $sformatf("rand%0d_w%0d_m%0d", i, w, m));
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
